// File: rtl/text_line_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : text_line_buffer_if
// Description : Byte-stream valid/ready handshake into the text line buffer.
//               Signals:
//                 in_valid  master->slave  in_char is valid
//                 in_char   master->slave  input byte
//                 in_ready  slave->master  byte accepted when in_valid=1
// Revision    : 1.0 - initial release
// ============================================================================
interface text_line_buffer_if;
    logic       in_valid;
    logic [7:0] in_char;
    logic       in_ready;

    modport master (
        output in_valid,
        output in_char,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_char,
        output in_ready
    );
endinterface
`default_nettype wire

// File: rtl/text_line_buffer.sv
`default_nettype none
// ============================================================================
// Module      : text_line_buffer
// Description : Editable working text line (append / backspace / clear) fed
//               from a valid/ready byte stream. On a frame tick the line is
//               copied into a display buffer that feeds the text renderer, so
//               the displayed text only changes during vertical blanking.
// Ports       :
//   clk         system/pixel clock
//   rst         synchronous reset, active-high
//   bus         slave side of the byte handshake (in_valid, in_char, in_ready)
//   vsync_tick  one-cycle pulse at start of vertical blanking
//   character   display buffer, one byte per cell, 0 = blank
//   cursor      next write position, 0..LINE_LEN
//   busy        high while clearing or copying
//   overflow    sticky: a printable byte was dropped on a full line
//   bad_char    one-cycle pulse: accepted byte was not recognised
// Revision    : 1.0 - initial release
// ============================================================================
module text_line_buffer #(
    parameter int         LINE_LEN  = 40,
    parameter int         ARRAY_LEN = 41,
    parameter logic [7:0] CHAR_MIN  = 8'd48,
    parameter logic [7:0] CHAR_MAX  = 8'd90
) (
    input  wire logic                clk,
    input  wire logic                rst,
    text_line_buffer_if.slave        bus,
    input  wire logic                vsync_tick,
    output logic [7:0]               character [0:ARRAY_LEN-1],
    output logic [5:0]               cursor,
    output logic                     busy,
    output logic                     overflow,
    output logic                     bad_char
);

    localparam logic [5:0] c_LINE_LEN  = 6'(LINE_LEN);
    localparam logic [5:0] c_LAST_LINE = 6'(LINE_LEN - 1);
    localparam logic [5:0] c_LAST_ARR  = 6'(ARRAY_LEN - 1);
    localparam logic [7:0] c_BS        = 8'h08;
    localparam logic [7:0] c_CR        = 8'h0D;
    localparam logic [7:0] c_SP        = 8'h20;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_COPY  = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_next;

    logic [7:0] r_work [0:LINE_LEN-1];
    logic [7:0] r_disp [0:ARRAY_LEN-1];
    logic [5:0] r_cursor;
    logic [5:0] r_idx;
    logic       r_dirty;
    logic       r_pend;
    logic       r_overflow;
    logic       r_bad_char;

    logic       w_xfer;
    logic       w_tick_eff;
    logic       w_is_glyph;
    logic       w_is_cr;

    assign w_xfer     = bus.in_valid && (r_state == S_IDLE);
    // A tick remembered while busy behaves exactly like a fresh tick once idle.
    assign w_tick_eff = vsync_tick || r_pend;
    assign w_is_glyph = ((bus.in_char >= CHAR_MIN) && (bus.in_char <= CHAR_MAX))
                        || (bus.in_char == c_SP);
    assign w_is_cr    = (bus.in_char == c_CR);

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic. A byte transfer in IDLE takes priority over starting a
    // copy; the coincident tick is parked in r_pend so the copy sees the byte.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_xfer && w_is_cr) begin
                    w_state_next = S_CLEAR;
                end else if (!w_xfer && w_tick_eff && r_dirty) begin
                    w_state_next = S_COPY;
                end
            end
            S_CLEAR: begin
                if (r_idx == c_LAST_LINE) begin
                    w_state_next = S_IDLE;
                end
            end
            S_COPY: begin
                if (r_idx == c_LAST_ARR) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath: working line edits, clear sweep, frame copy
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LINE_LEN; i++) begin
                r_work[i] <= 8'h00;
            end
            for (int i = 0; i < ARRAY_LEN; i++) begin
                r_disp[i] <= 8'h00;
            end
            r_cursor   <= 6'd0;
            r_idx      <= 6'd0;
            r_dirty    <= 1'b0;
            r_pend     <= 1'b0;
            r_overflow <= 1'b0;
            r_bad_char <= 1'b0;
        end else begin
            r_bad_char <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_xfer) begin
                        if (w_tick_eff) begin
                            r_pend <= 1'b1;
                        end
                        if (w_is_glyph) begin
                            if (r_cursor < c_LINE_LEN) begin
                                // Space is rendered as a blank cell.
                                r_work[r_cursor] <= (bus.in_char == c_SP) ? 8'h00 : bus.in_char;
                                r_cursor         <= r_cursor + 6'd1;
                                r_dirty          <= 1'b1;
                            end else begin
                                r_overflow <= 1'b1;
                            end
                        end else if (bus.in_char == c_BS) begin
                            if (r_cursor != 6'd0) begin
                                r_work[r_cursor - 6'd1] <= 8'h00;
                                r_cursor                <= r_cursor - 6'd1;
                                r_dirty                 <= 1'b1;
                            end
                        end else if (w_is_cr) begin
                            r_idx <= 6'd0;
                        end else begin
                            r_bad_char <= 1'b1;
                        end
                    end else if (w_tick_eff) begin
                        // A stale pending tick with nothing new to show is dropped.
                        r_pend <= 1'b0;
                        if (r_dirty) begin
                            r_idx   <= 6'd0;
                            r_dirty <= 1'b0;
                        end
                    end
                end
                S_CLEAR: begin
                    if (vsync_tick) begin
                        r_pend <= 1'b1;
                    end
                    r_work[r_idx] <= 8'h00;
                    r_idx         <= r_idx + 6'd1;
                    if (r_idx == c_LAST_LINE) begin
                        r_cursor   <= 6'd0;
                        r_overflow <= 1'b0;
                        r_dirty    <= 1'b1;
                    end
                end
                S_COPY: begin
                    if (vsync_tick) begin
                        r_pend <= 1'b1;
                    end
                    // Cells beyond the editable line are always blank.
                    r_disp[r_idx] <= (r_idx < c_LINE_LEN) ? r_work[r_idx] : 8'h00;
                    r_idx         <= r_idx + 6'd1;
                end
                default: begin
                    r_idx <= 6'd0;
                end
            endcase
        end
    end

    assign bus.in_ready = (r_state == S_IDLE);
    assign busy         = (r_state == S_CLEAR) || (r_state == S_COPY);
    assign character    = r_disp;
    assign cursor       = r_cursor;
    assign overflow     = r_overflow;
    assign bad_char     = r_bad_char;

endmodule
`default_nettype wire

// File: tb/tb_text_line_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_text_line_buffer
// Description : Directed self-checking bench for text_line_buffer. A small
//               line model predicts each displayed frame; predictions are
//               queued when a copy is triggered and compared once the copy
//               completes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_text_line_buffer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       vsync_tick = 1'b0;
    logic [7:0] character [0:40];
    logic [5:0] cursor;
    logic       busy;
    logic       overflow;
    logic       bad_char;

    text_line_buffer_if bus ();

    text_line_buffer dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .vsync_tick (vsync_tick),
        .character  (character),
        .cursor     (cursor),
        .busy       (busy),
        .overflow   (overflow),
        .bad_char   (bad_char)
    );

    always #5 clk = ~clk;

    int            n_assert = 0;
    int            n_fail   = 0;
    logic [7:0]    m_work [0:39];
    int            m_cur;
    logic          m_ovf;
    logic [327:0]  exp_q [$];

    task automatic chk(input string tag, input logic [327:0] obs, input logic [327:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [327:0] pack_dut();
        logic [327:0] v;
        v = '0;
        for (int i = 0; i < 41; i++) v[(40-i)*8 +: 8] = character[i];
        return v;
    endfunction

    function automatic logic [327:0] pack_model();
        logic [327:0] v;
        v = '0;
        for (int i = 0; i < 40; i++) v[(40-i)*8 +: 8] = m_work[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 40; i++) m_work[i] = 8'h00;
        m_cur = 0;
        m_ovf = 1'b0;
    endtask

    task automatic model_byte(input logic [7:0] b, output logic bad);
        bad = 1'b0;
        if ((b >= 8'd48 && b <= 8'd90) || b == 8'h20) begin
            if (m_cur < 40) begin
                m_work[m_cur] = (b == 8'h20) ? 8'h00 : b;
                m_cur++;
            end else begin
                m_ovf = 1'b1;
            end
        end else if (b == 8'h08) begin
            if (m_cur > 0) begin
                m_cur--;
                m_work[m_cur] = 8'h00;
            end
        end else if (b == 8'h0D) begin
            model_reset();
        end else begin
            bad = 1'b1;
        end
    endtask

    task automatic send(input logic [7:0] b, input string tag);
        logic exp_bad;
        bus.in_valid = 1'b1;
        bus.in_char  = b;
        step();
        bus.in_valid = 1'b0;
        model_byte(b, exp_bad);
        chk({tag, "_bad_char"}, 328'(bad_char), 328'(exp_bad));
    endtask

    // Called on the first sample after the copy has been triggered.
    task automatic wait_copy(input string tag);
        int n;
        logic [327:0] exp;
        n = 0;
        while (busy && n < 100) begin
            step();
            n++;
        end
        chk({tag, "_copy_len"}, 328'(n), 328'(41));
        chk({tag, "_queue"}, 328'(exp_q.size() > 0), 328'(1));
        if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            chk({tag, "_display"}, pack_dut(), exp);
        end
    endtask

    task automatic tick_copy(input string tag);
        vsync_tick = 1'b1;
        step();
        vsync_tick = 1'b0;
        exp_q.push_back(pack_model());
        chk({tag, "_copy_start"}, 328'(busy), 328'(1));
        wait_copy(tag);
    endtask

    initial begin
        int n;
        logic rdy_seen;
        logic dummy;
        bus.in_valid = 1'b0;
        bus.in_char  = 8'h00;
        model_reset();

        // Reset state
        step();
        step();
        rst = 1'b0;
        chk("rst_cursor",   328'(cursor),       328'(0));
        chk("rst_in_ready", 328'(bus.in_ready), 328'(1));
        chk("rst_busy",     328'(busy),         328'(0));
        chk("rst_overflow", 328'(overflow),     328'(0));
        chk("rst_display",  pack_dut(),         '0);

        // 1: "A1B" then a frame copy
        send(8'h41, "t1_A");
        send(8'h31, "t1_1");
        send(8'h42, "t1_B");
        tick_copy("t1");
        chk("t1_cursor", 328'(cursor), 328'(3));
        chk("t1_cells",  328'({character[0], character[1], character[2], character[3]}),
            328'(32'h41314200));

        // 2: fill the line and overrun it by one
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 41; i++) send(8'(48 + (i % 43)), "t2_fill");
        chk("t2_cursor",   328'(cursor),   328'(40));
        chk("t2_overflow", 328'(overflow), 328'(1));
        tick_copy("t2");
        chk("t2_last_cell", 328'(character[40]), 328'(0));

        // 4: CR with a simultaneous tick -> clear, then the pending copy
        bus.in_valid = 1'b1;
        bus.in_char  = 8'h0D;
        vsync_tick   = 1'b1;
        step();
        bus.in_valid = 1'b0;
        vsync_tick   = 1'b0;
        model_byte(8'h0D, dummy);
        exp_q.push_back(pack_model());
        n = 0;
        rdy_seen = 1'b0;
        while (busy && n < 100) begin
            if (bus.in_ready) rdy_seen = 1'b1;
            step();
            n++;
        end
        chk("t4_clear_len", 328'(n),        328'(40));
        chk("t4_ready_low", 328'(rdy_seen), 328'(0));
        chk("t4_overflow",  328'(overflow), 328'(0));
        chk("t4_cursor",    328'(cursor),   328'(0));
        step();
        chk("t4_copy_start", 328'(busy), 328'(1));
        wait_copy("t4");

        // 3: backspace past the start of the line
        send(8'h41, "t3_A");
        send(8'h42, "t3_B");
        send(8'h08, "t3_bs1");
        send(8'h08, "t3_bs2");
        send(8'h08, "t3_bs3");
        chk("t3_cursor", 328'(cursor), 328'(0));
        tick_copy("t3");

        // 5: unrecognised byte, then a tick with nothing new to show
        send(8'h7F, "t5_del");
        step();
        chk("t5_bad_pulse_end", 328'(bad_char), 328'(0));
        chk("t5_cursor",        328'(cursor),   328'(0));
        vsync_tick = 1'b1;
        step();
        vsync_tick = 1'b0;
        chk("t5_no_copy", 328'(busy), 328'(0));
        step();
        chk("t5_no_copy_later", 328'(busy), 328'(0));
        chk("t5_display",       pack_dut(),  '0);

        // 6: reset in the middle of a copy
        send(8'h5A, "t6_Z");
        send(8'h59, "t6_Y");
        tick_copy("t6_pre");
        send(8'h58, "t6_X");
        vsync_tick = 1'b1;
        step();
        vsync_tick = 1'b0;
        for (int i = 0; i < 20; i++) step();
        chk("t6_mid_copy", 328'(busy), 328'(1));
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_reset();
        chk("t6_display",  pack_dut(),         '0);
        chk("t6_busy",     328'(busy),         328'(0));
        chk("t6_in_ready", 328'(bus.in_ready), 328'(1));
        chk("t6_cursor",   328'(cursor),       328'(0));

        // 7: transfer and tick on the same edge -> copy includes the byte
        bus.in_valid = 1'b1;
        bus.in_char  = 8'h43;
        vsync_tick   = 1'b1;
        step();
        bus.in_valid = 1'b0;
        vsync_tick   = 1'b0;
        model_byte(8'h43, dummy);
        exp_q.push_back(pack_model());
        chk("t7_write_first", 328'(busy), 328'(0));
        step();
        chk("t7_copy_start", 328'(busy), 328'(1));
        wait_copy("t7");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
